dds_freq_meter: RTL and testbench

- Receive-side counterpart of the DDS phase accumulator: measures the frequency of a square-wave input (e.g. a DDS MSB / F_out) and converts it back into a 32-bit frequency tuning word K in the same units the DDS consumes (f = K·f_clk/2^32).
- Counts rising edges over a gate of exactly 2^GATE_LOG2 clk cycles and left-shifts the count, so no divider is needed.
- Used for closed-loop DDS self-check and for calibrating K against external sources.

---
 rtl/dds_freq_meter.sv | 127 ++++++++++++
 tb/tb_dds_freq_meter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_freq_meter.sv
// Frequency meter: counts rising edges of sig_in over a 2^GATE_LOG2-cycle gate and reports a DDS tuning word.
// Build option: define DDS_FM_CONT_EN for continuous measurement after the first start.
module dds_freq_meter #(
  parameter int GATE_LOG2 = 16,
  parameter int K_W       = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sig_in,
  input  logic           start,
  output logic           busy,
  output logic [K_W-1:0] k_out,
  output logic           k_valid,
  output logic           no_sig
);

  // state | meaning
  // IDLE  | waiting for start; counters held at zero
  // ARM   | waiting for the alignment edge (not counted); times out after a full gate
  // MEAS  | counting edges for exactly 2^GATE_LOG2 cycles
  // DONE  | one cycle; result presented with k_valid
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;

  localparam logic [GATE_LOG2-1:0] GATE_MAX = '1;
  localparam logic [GATE_LOG2-1:0] GATE_ONE = 1;
  localparam logic [GATE_LOG2:0]   EDGE_MAX = '1;
  localparam logic [GATE_LOG2:0]   EDGE_ONE = 1;
  localparam int                   SHIFT    = K_W - GATE_LOG2;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, sync3_q, edge_p_q;
  logic [GATE_LOG2-1:0] gate_q, gate_d;
  logic [GATE_LOG2:0]   edge_cnt_q, edge_cnt_d;
  logic [K_W-1:0]       k_out_q, k_out_d;
  logic                 no_sig_q, no_sig_d;
  logic                 gate_tc;

  assign gate_tc = (gate_q == GATE_MAX);

  // Two-flop synchroniser plus registered rise detect: 3 clk from sig_in rise to edge_p_q.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      edge_p_q <= 1'b0;
    end else begin
      sync1_q  <= sig_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      edge_p_q <= sync2_q & ~sync3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM: begin
        if (edge_p_q)     state_d = S_MEAS;
        else if (gate_tc) state_d = S_DONE;
      end
      S_MEAS: if (gate_tc) state_d = S_DONE;
`ifdef DDS_FM_CONT_EN
      S_DONE: state_d = S_ARM;
`else
      S_DONE: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    k_valid = (state_q == S_DONE);
  end

  // Result registers load on the way into DONE so k_out is already valid alongside k_valid.
  always_comb begin
    gate_d     = '0;
    edge_cnt_d = '0;
    k_out_d    = k_out_q;
    no_sig_d   = no_sig_q;
    case (state_q)
      S_ARM: begin
        gate_d = edge_p_q ? '0 : gate_q + GATE_ONE;
        if (!edge_p_q && gate_tc) begin
          k_out_d  = '0;
          no_sig_d = 1'b1;
        end
      end
      S_MEAS: begin
        gate_d = gate_q + GATE_ONE;
        if (edge_p_q && (edge_cnt_q != EDGE_MAX)) edge_cnt_d = edge_cnt_q + EDGE_ONE;
        else                                      edge_cnt_d = edge_cnt_q;
        if (gate_tc) begin
          k_out_d  = K_W'(edge_cnt_d) << SHIFT;
          no_sig_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      gate_q     <= '0;
      edge_cnt_q <= '0;
      k_out_q    <= '0;
      no_sig_q   <= 1'b0;
    end else begin
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      k_out_q    <= k_out_d;
      no_sig_q   <= no_sig_d;
    end
  end

  assign k_out  = k_out_q;
  assign no_sig = no_sig_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Self-checking bench for dds_freq_meter (GATE_LOG2=8, K_W=32); expected words come from edge-rate arithmetic.
module tb_dds_freq_meter;
  localparam int GL = 8;
  localparam int KW = 32;

  logic        clk = 1'b0;
  logic        rst_n, sig_in, start;
  logic        busy, k_valid, no_sig;
  logic [31:0] k_out;

  int n_cmp = 0;
  int n_err = 0;

  // signal generator controls: 0 = constant level, 1 = periodic, 2 = DDS MSB
  int          mode = 0;
  int          per  = 16;
  int          hi   = 8;
  int          ph   = 0;
  logic        lvl  = 1'b0;
  logic [31:0] dds_k = 0;
  logic [31:0] dds_acc = 0;

  logic [31:0] k_got;
  logic        ns_got;
  int          lat;
  int          vcount;
  int          p, h;
  logic [31:0] kk, diff;
  logic        seen;

  always #5 clk = ~clk;

  dds_freq_meter #(.GATE_LOG2(GL), .K_W(KW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .start   (start),
    .busy    (busy),
    .k_out   (k_out),
    .k_valid (k_valid),
    .no_sig  (no_sig)
  );

  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        1: begin
          ph     = (ph + 1 >= per) ? 0 : ph + 1;
          sig_in = (ph < hi);
        end
        2: begin
          dds_acc = dds_acc + dds_k;
          sig_in  = dds_acc[31];
        end
        default: sig_in = lvl;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Edges seen in a 256-cycle window following an alignment edge of a strictly periodic wave.
  function automatic logic [31:0] exp_k(input int period);
    longint v;
    v = (longint'(1 << GL) / period) << (KW - GL);
    return v[31:0];
  endfunction

  task automatic set_period(input int pp, input int hh);
    per  = pp;
    hi   = hh;
    ph   = 0;
    mode = 1;
  endtask

  task automatic measure(input int extra, output logic [31:0] k, output logic ns, output int l);
    logic got;
    got = 1'b0;
    l   = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_on_arm", {31'b0, busy}, 1);
    for (int n = 0; n < 3000; n++) begin
      start = (extra != 0 && (n == 60 || n == 150));
      if (k_valid === 1'b1) begin
        got = 1'b1;
        l   = n;
        break;
      end
      tick();
    end
    start = 1'b0;
    check("kvalid_seen", {31'b0, got}, 1);
    k  = k_out;
    ns = no_sig;
    tick();
    check("kvalid_single", {31'b0, k_valid}, 0);
    check("busy_fall", {31'b0, busy}, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_kout", k_out, 0);
    check("rst_kvalid", {31'b0, k_valid}, 0);
    check("rst_nosig", {31'b0, no_sig}, 0);
    rst_n = 1'b0;
    repeat (2) tick();

`ifndef DDS_FM_CONT_EN
    set_period(16, 8);
    repeat (40) tick();
    measure(0, k_got, ns_got, lat);
    check("p16_k", k_got, 32'h1000_0000);
    check("p16_nosig", {31'b0, ns_got}, 0);

    set_period(2, 1);
    repeat (40) tick();
    measure(0, k_got, ns_got, lat);
    check("p2_k", k_got, 32'h8000_0000);
    check("p2_nosig", {31'b0, ns_got}, 0);

    mode = 0;
    lvl  = 1'b0;
    repeat (10) tick();
    measure(0, k_got, ns_got, lat);
    check("nosig_lat", lat, 256);
    check("nosig_k", k_got, 0);
    check("nosig_flag", {31'b0, ns_got}, 1);

    set_period(16, 8);
    repeat (40) tick();
    measure(0, k_got, ns_got, lat);
    check("recover_k", k_got, 32'h1000_0000);
    check("recover_nosig", {31'b0, ns_got}, 0);

    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(40, 2);
      h = $urandom_range(p - 1, 1);
      set_period(p, h);
      repeat (50) tick();
      measure(0, k_got, ns_got, lat);
      check("rand_period_k", k_got, exp_k(p));
      check("rand_period_nosig", {31'b0, ns_got}, 0);
    end

    for (int i = 0; i < 4; i++) begin
      kk = (i == 0) ? 32'h0400_0000 : $urandom_range(32'h4000_0000, 32'h0200_0000);
      dds_k   = kk;
      dds_acc = $urandom;
      mode    = 2;
      repeat (50) tick();
      measure(0, k_got, ns_got, lat);
      diff = (k_got > kk) ? k_got - kk : kk - k_got;
      check("dds_within_1lsb", {31'b0, (diff <= 32'h0100_0000)}, 1);
      check("dds_nosig", {31'b0, ns_got}, 0);
    end

    set_period(16, 8);
    repeat (40) tick();
    measure(1, k_got, ns_got, lat);
    check("extra_start_k", k_got, 32'h1000_0000);
    vcount = 0;
    for (int n = 0; n < 400; n++) begin
      if (k_valid === 1'b1) vcount++;
      tick();
    end
    check("extra_start_no_rerun", vcount, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (120) tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_kout", k_out, 0);
    check("midrst_kvalid", {31'b0, k_valid}, 0);
    check("midrst_nosig", {31'b0, no_sig}, 0);
    vcount = 0;
    for (int n = 0; n < 400; n++) begin
      if (k_valid === 1'b1) vcount++;
      tick();
    end
    check("midrst_no_kvalid", vcount, 0);
    measure(0, k_got, ns_got, lat);
    check("after_rst_k", k_got, 32'h1000_0000);
`else
    set_period(32, 16);
    repeat (40) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int n = 0; n < 700; n++) begin
        start = (n == 100);
        if (k_valid === 1'b1) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      start = 1'b0;
      check("cont_kvalid_seen", {31'b0, seen}, 1);
      check("cont_k", k_out, 32'h0800_0000);
      check("cont_nosig", {31'b0, no_sig}, 0);
      tick();
      check("cont_busy_held", {31'b0, busy}, 1);
      check("cont_kvalid_single", {31'b0, k_valid}, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
